// File: rtl/chess_board_loader.sv
// Captures the generator's packed 128-bit piece array and unpacks it into board RAM, one slot per cycle.
// Optional macro LOADER_SET_CHECK_EN builds per-(team,type) counters so set_ok reflects a legal full set.
module chess_board_loader #(
  parameter int N_SLOTS = 32,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              gen_ready,
  input  logic [127:0]      chess_arr,
  output logic              board_we,
  output logic [ADDR_W-1:0] board_addr,
  output logic [3:0]        board_data,
  output logic              busy,
  output logic              done,
  output logic [5:0]        red_cnt,
  output logic [5:0]        blk_cnt,
  output logic              set_ok
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_GEN,
    S_WRITE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [127:0]        shadow_q, shadow_d;
  logic [5:0]          red_cnt_q, red_cnt_d;
  logic [5:0]          blk_cnt_q, blk_cnt_d;
  logic                set_ok_q, set_ok_d;
  logic [3:0]          slot;

  assign slot = shadow_q[{idx_q, 2'b00} +: 4];

`ifdef LOADER_SET_CHECK_EN
  // Indexed by the full piece code {team, type}; type-0 entries are never incremented.
  logic [5:0] type_cnt_q [16];
  logic [5:0] type_cnt_d [16];
  logic       set_legal;

  function automatic logic [5:0] required_cnt(input logic [3:0] code);
    case (code[2:0])
      3'd0:    required_cnt = 6'd0;
      3'd1:    required_cnt = 6'd1;
      3'd7:    required_cnt = 6'd5;
      default: required_cnt = 6'd2;
    endcase
  endfunction

  always_comb begin
    set_legal = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (type_cnt_q[i] != required_cnt(4'(i))) set_legal = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) type_cnt_q <= '{default: '0};
    else     type_cnt_q <= type_cnt_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      shadow_q  <= '0;
      red_cnt_q <= '0;
      blk_cnt_q <= '0;
      set_ok_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      red_cnt_q <= red_cnt_d;
      blk_cnt_q <= blk_cnt_d;
      set_ok_q  <= set_ok_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    red_cnt_d = red_cnt_q;
    blk_cnt_d = blk_cnt_q;
    set_ok_d  = set_ok_q;
`ifdef LOADER_SET_CHECK_EN
    type_cnt_d = type_cnt_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_WAIT_GEN;
          idx_d     = '0;
          red_cnt_d = '0;
          blk_cnt_d = '0;
          set_ok_d  = 1'b0;
`ifdef LOADER_SET_CHECK_EN
          type_cnt_d = '{default: '0};
`endif
        end
      end
      S_WAIT_GEN: begin
        if (gen_ready) begin
          shadow_d = chess_arr;
          idx_d    = '0;
          state_d  = S_WRITE;
        end
      end
      S_WRITE: begin
        if (slot[2:0] != 3'd0) begin
          if (slot[3]) red_cnt_d = red_cnt_q + 6'd1;
          else         blk_cnt_d = blk_cnt_q + 6'd1;
`ifdef LOADER_SET_CHECK_EN
          type_cnt_d[slot] = type_cnt_q[slot] + 6'd1;
`endif
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == ADDR_W'(N_SLOTS - 1)) state_d = S_CHECK;
      end
      S_CHECK: begin
`ifdef LOADER_SET_CHECK_EN
        set_ok_d = set_legal;
`else
        set_ok_d = 1'b1;
`endif
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Write port depends only on registered state so the RAM sees no input-to-output path.
  assign board_we   = (state_q == S_WRITE);
  assign board_addr = board_we ? idx_q : '0;
  assign board_data = board_we ? slot : 4'd0;
  assign busy       = (state_q == S_WAIT_GEN) || (state_q == S_WRITE) || (state_q == S_CHECK);
  assign done       = (state_q == S_DONE);
  assign red_cnt    = red_cnt_q;
  assign blk_cnt    = blk_cnt_q;
  assign set_ok     = set_ok_q;

endmodule

// File: tb/tb_chess_board_loader.sv
// Directed self-checking bench for chess_board_loader; expectations follow LOADER_SET_CHECK_EN when defined.
module tb_chess_board_loader;

  logic         clk;
  logic         rst;
  logic         start;
  logic         gen_ready;
  logic [127:0] chess_arr;
  logic         board_we;
  logic [4:0]   board_addr;
  logic [3:0]   board_data;
  logic         busy;
  logic         done;
  logic [5:0]   red_cnt;
  logic [5:0]   blk_cnt;
  logic         set_ok;

  int total;
  int bad;
  int cyc;
  int wr_n;
  int wr_cyc0;
  logic [4:0] wr_addr [64];
  logic [3:0] wr_data [64];

  int         lat;
  int         e0;
  logic       busy_e0;
  logic       done_e0;
  logic       ok_pre;
  logic [5:0] red_pre;
  logic [5:0] blk_pre;

`ifdef LOADER_SET_CHECK_EN
  localparam logic ILLEGAL_OK = 1'b0;
`else
  localparam logic ILLEGAL_OK = 1'b1;
`endif

  chess_board_loader #(.N_SLOTS(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .gen_ready(gen_ready), .chess_arr(chess_arr),
    .board_we(board_we), .board_addr(board_addr), .board_data(board_data),
    .busy(busy), .done(done), .red_cnt(red_cnt), .blk_cnt(blk_cnt), .set_ok(set_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every RAM write on the falling edge, away from the update edge.
  always @(negedge clk) begin
    if (board_we) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] = board_addr;
        wr_data[wr_n] = board_data;
        if (wr_n == 0) wr_cyc0 = cyc;
      end
      wr_n++;
    end
  end

  // Even slots red, odd slots black; each side gets G, 2A, 2E, 2R, 2H, 2C, 5S.
  function automatic logic [127:0] make_legal();
    logic [127:0] a;
    int t;
    a = '0;
    for (int i = 0; i < 16; i++) begin
      if (i == 0)      t = 1;
      else if (i < 11) t = 2 + (i - 1) / 2;
      else             t = 7;
      a[8*i +: 4]     = {1'b1, 3'(t)};
      a[8*i + 4 +: 4] = {1'b0, 3'(t)};
    end
    return a;
  endfunction

  // Drives one start-to-done load and records observations for the calling test.
  task automatic do_load(input logic [127:0] arr, input bit disturb);
    chess_arr = arr;
    gen_ready = 1'b1;
    wr_n      = 0;
    wr_cyc0   = -1;
    lat       = -1;
    ok_pre    = 1'bx;
    red_pre   = 'x;
    blk_pre   = 'x;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    e0      = cyc;
    busy_e0 = busy;
    done_e0 = done;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (disturb && n == 1) begin
        chess_arr = '0;
        gen_ready = 1'b0;
      end
      start = disturb && (n == 5 || n == 20);
      if (n == 33) begin
        ok_pre  = set_ok;
        red_pre = red_cnt;
        blk_pre = blk_cnt;
      end
      if (done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if ({board_we, board_addr, board_data, busy, done, red_cnt, blk_cnt, set_ok} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got we=%b addr=%0d data=%h busy=%b done=%b red=%0d blk=%0d ok=%b, want all 0",
               board_we, board_addr, board_data, busy, done, red_cnt, blk_cnt, set_ok);
    end
    gen_ready = 1'b0;
    wr_n      = 0;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 20; n++) begin
      total++;
      if (busy !== 1'b1) begin
        bad++;
        $display("[TB] FAIL wait_busy cycle %0d: got busy=%b, want 1", n, busy);
      end
      @(posedge clk); #1;
    end
    total++;
    if (wr_n !== 0) begin
      bad++;
      $display("[TB] FAIL wait_no_writes: got %0d writes, want 0", wr_n);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_legal();
    logic [127:0] arr;
    arr = make_legal();
    do_load(arr, 1'b0);
    total++;
    if (busy_e0 !== 1'b1) begin bad++; $display("[TB] FAIL legal_busy: got %b, want 1", busy_e0); end
    total++;
    if (lat !== 34) begin bad++; $display("[TB] FAIL legal_latency: got %0d, want 34", lat); end
    total++;
    if (wr_cyc0 - e0 !== 1) begin bad++; $display("[TB] FAIL legal_first_write: got cycle %0d, want 1", wr_cyc0 - e0); end
    total++;
    if (wr_n !== 32) begin bad++; $display("[TB] FAIL legal_write_count: got %0d, want 32", wr_n); end
    for (int i = 0; i < 32; i++) begin
      total++;
      if (wr_addr[i] !== 5'(i) || wr_data[i] !== arr[4*i +: 4]) begin
        bad++;
        $display("[TB] FAIL legal_write %0d: got addr=%0d data=%h, want addr=%0d data=%h",
                 i, wr_addr[i], wr_data[i], i, arr[4*i +: 4]);
      end
    end
    total++;
    if (ok_pre !== 1'b0 || red_pre !== 6'd16 || blk_pre !== 6'd16) begin
      bad++;
      $display("[TB] FAIL legal_at_e33: got ok=%b red=%0d blk=%0d, want ok=0 red=16 blk=16", ok_pre, red_pre, blk_pre);
    end
    total++;
    if (red_cnt !== 6'd16 || blk_cnt !== 6'd16) begin
      bad++;
      $display("[TB] FAIL legal_counts: got red=%0d blk=%0d, want 16/16", red_cnt, blk_cnt);
    end
    total++;
    if (set_ok !== 1'b1) begin bad++; $display("[TB] FAIL legal_set_ok: got %b, want 1", set_ok); end
  endtask

  task automatic test_illegal();
    logic [127:0] arr;
    arr = {32{4'hE}};
    do_load(arr, 1'b0);
    total++;
    if (lat !== 34) begin bad++; $display("[TB] FAIL illegal_latency: got %0d, want 34", lat); end
    total++;
    if (red_cnt !== 6'd32 || blk_cnt !== 6'd0) begin
      bad++;
      $display("[TB] FAIL illegal_counts: got red=%0d blk=%0d, want 32/0", red_cnt, blk_cnt);
    end
    total++;
    if (set_ok !== ILLEGAL_OK) begin bad++; $display("[TB] FAIL illegal_set_ok: got %b, want %b", set_ok, ILLEGAL_OK); end
  endtask

  task automatic test_shadow();
    logic [127:0] arr;
    arr = make_legal();
    do_load(arr, 1'b1);
    total++;
    if (lat !== 34) begin bad++; $display("[TB] FAIL shadow_latency: got %0d, want 34", lat); end
    total++;
    if (wr_n !== 32) begin bad++; $display("[TB] FAIL shadow_write_count: got %0d, want 32", wr_n); end
    for (int i = 0; i < 32; i++) begin
      total++;
      if (wr_addr[i] !== 5'(i) || wr_data[i] !== arr[4*i +: 4]) begin
        bad++;
        $display("[TB] FAIL shadow_write %0d: got addr=%0d data=%h, want addr=%0d data=%h",
                 i, wr_addr[i], wr_data[i], i, arr[4*i +: 4]);
      end
    end
    total++;
    if (red_cnt !== 6'd16 || blk_cnt !== 6'd16 || set_ok !== 1'b1) begin
      bad++;
      $display("[TB] FAIL shadow_result: got red=%0d blk=%0d ok=%b, want 16/16 ok=1", red_cnt, blk_cnt, set_ok);
    end
  endtask

  task automatic test_reload();
    total++;
    if (done !== 1'b1) begin bad++; $display("[TB] FAIL reload_pre_done: got %b, want 1", done); end
    do_load({32{4'h1}}, 1'b0);
    total++;
    if (done_e0 !== 1'b0 || busy_e0 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reload_restart: got done=%b busy=%b, want done=0 busy=1", done_e0, busy_e0);
    end
    total++;
    if (lat !== 34) begin bad++; $display("[TB] FAIL reload_latency: got %0d, want 34", lat); end
    total++;
    if (red_cnt !== 6'd0 || blk_cnt !== 6'd32) begin
      bad++;
      $display("[TB] FAIL reload_counts: got red=%0d blk=%0d, want 0/32", red_cnt, blk_cnt);
    end
    total++;
    if (set_ok !== ILLEGAL_OK) begin bad++; $display("[TB] FAIL reload_set_ok: got %b, want %b", set_ok, ILLEGAL_OK); end
  endtask

  task automatic test_reset_mid_write();
    chess_arr = make_legal();
    gen_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    total++;
    if (board_we !== 1'b1 || board_addr !== 5'd10 || red_cnt !== 6'd5 || blk_cnt !== 6'd5) begin
      bad++;
      $display("[TB] FAIL midwrite_idx10: got we=%b addr=%0d red=%0d blk=%0d, want we=1 addr=10 red=5 blk=5",
               board_we, board_addr, red_cnt, blk_cnt);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (board_we !== 1'b0 || red_cnt !== 6'd0 || blk_cnt !== 6'd0 || done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midwrite_after_rst: got we=%b red=%0d blk=%0d done=%b busy=%b, want all 0",
               board_we, red_cnt, blk_cnt, done, busy);
    end
    do_load(make_legal(), 1'b0);
    total++;
    if (wr_n !== 32 || lat !== 34) begin
      bad++;
      $display("[TB] FAIL midwrite_reload: got writes=%0d latency=%0d, want 32 and 34", wr_n, lat);
    end
    total++;
    if (red_cnt !== 6'd16 || blk_cnt !== 6'd16 || set_ok !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midwrite_reload_result: got red=%0d blk=%0d ok=%b, want 16/16 ok=1", red_cnt, blk_cnt, set_ok);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    wr_n      = 0;
    wr_cyc0   = -1;
    rst       = 1'b1;
    start     = 1'b0;
    gen_ready = 1'b0;
    chess_arr = '0;
    test_reset();
    test_legal();
    test_illegal();
    test_shadow();
    test_reload();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chess_board_loader.md
# chess_board_loader

Consumer side of the random piece generator: waits for the generator's ready flag, captures the packed 128-bit piece array, and unpacks it into the board memory, one 4-bit piece code per cycle, across 32 consecutive write cycles. It also tallies pieces per side and, optionally, checks that the array is a legal full dark-chess set. It sits between the generator and the board RAM that the game logic and VGA renderer read.

## Interface
- `N_SLOTS`, 32: number of board cells and packed slots. It is fixed by the 128-bit array width.
- `ADDR_W`, 5: board address width.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle request to load a new board. It is honoured only in IDLE or DONE.
- `gen_ready` in 1: generator ready flag (array complete and stable).
- `chess_arr` in 128: packed array. Slot i = `chess_arr[4i+3:4i]`. Bit 3 is the team (1 = red), bits 2:0 are the type (0 = none, 1..7 = general, advisor, elephant, chariot, horse, cannon, soldier).
- `board_we` out 1: board RAM write enable.
- `board_addr` out ADDR_W: write address (slot index).
- `board_data` out 4: piece code written.
- `busy` out 1: high in WAIT_GEN, WRITE and CHECK.
- `done` out 1: high in DONE.
- `red_cnt` out 6: number of red pieces written (type ≠ 0).
- `blk_cnt` out 6: number of black pieces written (type ≠ 0).
- `set_ok` out 1: the loaded array is a legal full set.

## Operation
- States:
  - IDLE.
  - WAIT_GEN.
  - WRITE (slot index `idx` runs 0..31).
  - CHECK.
  - DONE.
- Transitions:
  - IDLE, `start` → WAIT_GEN. This also clears the counters, `set_ok` and `idx`.
  - WAIT_GEN, `gen_ready` = 1 → latch `chess_arr` into a shadow register, `idx` ← 0, go to WRITE. If `gen_ready` = 0, stay in WAIT_GEN; there is no timeout.
  - WRITE: `board_we` = 1, `board_addr` = `idx`, `board_data` = shadow slot `idx`. At each edge `idx` increments; when `idx` = 31, go to CHECK.
  - CHECK: evaluate `set_ok`, then go to DONE.
  - DONE: hold all outputs. `start` → WAIT_GEN, with the same clearing as from IDLE.
- `start` in WAIT_GEN, WRITE or CHECK is ignored.
- All writes use the shadow copy. Changes on `chess_arr` or `gen_ready` after the latch edge have no effect.
- Counting happens at each WRITE edge:
  - The slot's code increments `red_cnt` or `blk_cnt` according to bit 3, only if the type ≠ 0.
  - Internal 6-bit per-(team,type) counters increment the same way.
  - No counter can exceed 32, so no saturation is needed.
- `board_we`, `board_addr` and `board_data` are decoded from the state and `idx` register only; they have no combinational path from inputs.
- Outside WRITE: `board_we` = 0, and `board_addr` and `board_data` are 0.

## Timing
- Reset values: state IDLE, all outputs 0, `idx` = 0, all counters 0.
- `rst` mid-operation: the next edge returns to IDLE. `board_we` is 0 from that edge on; counts and `done` are cleared. A partially written board is left as is.
- Latency with `gen_ready` already high and `start` sampled at edge E0:
  - latch at E1;
  - writes to addr 0..31 occur in the cycles following E1..E32;
  - CHECK follows E33;
  - `done` = 1 from E34.
  - Total: 34 cycles from start to done.
- Each additional cycle `gen_ready` is low in WAIT_GEN adds one cycle.
- `red_cnt` and `blk_cnt` are final from E33 and valid while `done` = 1.
- `set_ok` is registered at the CHECK→DONE edge (E34). It is 0 before that edge.

## Configuration
- `LOADER_SET_CHECK_EN` defined:
  - CHECK compares the 14 per-(team,type) counters against 1 general, 2 advisors, 2 elephants, 2 chariots, 2 horses, 2 cannons and 5 soldiers per side, with no empty slots.
  - `set_ok` = 1 only on an exact match.
- Not defined:
  - The per-type counters are not built.
  - `set_ok` is driven 1 at the CHECK→DONE edge and cleared on `start` or `rst`.
  - `red_cnt` and `blk_cnt` are unaffected.

## Test plan
- Reset: hold `rst` 2 cycles → all outputs 0 and `busy` = 0. `start` with `gen_ready` = 0 → `busy` = 1 with no writes for 20 cycles.
- Legal set:
  - Stimulus: array holding one full legal set, `gen_ready` = 1, `start` pulse at E0.
  - Response: 32 writes with addr 0..31 and data = slots 0..31; `done` at E34; `red_cnt` = 16, `blk_cnt` = 16; `set_ok` = 1 in both macro builds.
- Illegal set:
  - Stimulus: all slots 0xE (red cannon).
  - Response: `red_cnt` = 32, `blk_cnt` = 0; `set_ok` = 0 with `LOADER_SET_CHECK_EN`, 1 without.
- Shadow capture:
  - Stimulus: after the latch edge, drive `chess_arr` to all 0x0.
  - Response: the written data still equals the latched array; `start` pulses during WRITE cause no restart and `done` still rises at E34.
- Reset mid-write:
  - Stimulus: assert `rst` while `idx` = 10.
  - Response: `board_we` = 0 the next cycle, counts 0, `done` 0. A following `start` performs a complete 32-write load.
- Reload from DONE:
  - Stimulus: in DONE, `start` with an array of all 0x1 (black general).
  - Response: `done` drops the next cycle; after reload, `blk_cnt` = 32, `red_cnt` = 0, `set_ok` = 0 with the macro.
